// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and encodings for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshakes around the arbiter.
interface mem_port_arbiter_if;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        f_stall;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_rw;
    logic [1:0]  d_size;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    // Arbiter side.
    modport slave (
        input  f_req, f_addr, d_req, d_addr, d_wdata, d_rw, d_size, mem_ack, mem_rdata,
        output f_ack, f_rdata, f_stall, d_ack, d_rdata, d_stall,
               mem_req, mem_addr, mem_wdata, mem_rw, mem_size, err
    );

    // Pipeline stages plus memory, as seen from outside the arbiter.
    modport master (
        output f_req, f_addr, d_req, d_addr, d_wdata, d_rw, d_size, mem_ack, mem_rdata,
        input  f_ack, f_rdata, f_stall, d_ack, d_rdata, d_stall,
               mem_req, mem_addr, mem_wdata, mem_rw, mem_size, err
    );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// BUSY-state timeout counter; expired is raised on the last allowed cycle.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    assign expired = enable && (count_q == LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes fetch and data requests onto one memory port; data has priority
// bounded by a fetch anti-starvation streak. Optional watchdog: MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    arb_state_t  state_q, state_d;
    logic        owner_q;
    logic [3:0]  streak_q;
    logic        grant_data, grant_fetch, timeout_hit;
    logic        mem_req_q, mem_rw_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [1:0]  mem_size_q;
    logic        f_ack_q, d_ack_q, err_q;
    logic [31:0] f_rdata_q, d_rdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
    logic timed_out_q;

    mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q != BUSY),
        .enable  (state_q == BUSY),
        .expired (timeout_hit)
    );

    // Remember that the access was abandoned so err accompanies its ack.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timed_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= (state_q == RESP) && timed_out_q;
            if (grant_data || grant_fetch) begin
                timed_out_q <= 1'b0;
            end else if (state_q == BUSY && !bus.mem_ack && timeout_hit) begin
                timed_out_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
    assign err_q              = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests are only looked at in IDLE; anything raised meanwhile waits there.
    always_comb begin
        state_d     = state_q;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.d_req && !(bus.f_req && streak_q == STREAK_MAX)) begin
                    grant_data = 1'b1;
                    state_d    = BUSY;
                end else if (bus.f_req) begin
                    grant_fetch = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ack || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q     <= OWN_F;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rw_q    <= RW_READ;
            mem_size_q  <= SZ_BYTE;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            f_ack_q <= 1'b0;
            d_ack_q <= 1'b0;

            if (grant_data) begin
                owner_q     <= OWN_D;
                mem_req_q   <= 1'b1;
                mem_addr_q  <= bus.d_addr;
                mem_wdata_q <= bus.d_wdata;
                mem_rw_q    <= bus.d_rw;
                mem_size_q  <= bus.d_size;
                if (!bus.f_req) begin
                    streak_q <= '0;
                end else if (streak_q != STREAK_MAX) begin
                    streak_q <= streak_q + 4'd1;
                end
            end else if (grant_fetch) begin
                owner_q     <= OWN_F;
                mem_req_q   <= 1'b1;
                mem_addr_q  <= bus.f_addr;
                mem_wdata_q <= '0;
                mem_rw_q    <= RW_READ;
                mem_size_q  <= SZ_WORD;
                streak_q    <= '0;
            end

            // Stores return zero so a load consumer never sees stale bus data.
            if (state_q == BUSY && bus.mem_ack) begin
                mem_req_q <= 1'b0;
                if (owner_q == OWN_D) begin
                    d_rdata_q <= (mem_rw_q == RW_WRITE) ? 32'h0 : bus.mem_rdata;
                end else begin
                    f_rdata_q <= bus.mem_rdata;
                end
            end else if (state_q == BUSY && timeout_hit) begin
                mem_req_q <= 1'b0;
                if (owner_q == OWN_D) begin
                    d_rdata_q <= '0;
                end else begin
                    f_rdata_q <= '0;
                end
            end

            if (state_q == RESP) begin
                f_ack_q <= (owner_q == OWN_F);
                d_ack_q <= (owner_q == OWN_D);
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.f_ack     = f_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
    assign bus.f_stall   = bus.f_req & ~f_ack_q;
    assign bus.d_stall   = bus.d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; the timeout scenario runs only
// when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int MAX_STREAK = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`else
    localparam int TIMEOUT = 64;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rw;
        logic [1:0]  size;
    } grant_t;

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic clock = 1'b0;
    logic reset;
    mem_port_arbiter_if bus();

    grant_t      grant_q[$];
    resp_t       resp_q[$];
    logic [31:0] mem_image [logic [31:0]];
    int          mem_lat = 0;
    int          total   = 0;
    int          bad     = 0;

    mem_port_arbiter #(
        .MAX_DATA_STREAK (MAX_STREAK),
        .TIMEOUT_CYCLES  (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic owner, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic rw, input logic [1:0] size,
                                  input logic [31:0] rdata, input logic err);
        grant_q.push_back('{addr: addr, wdata: wdata, rw: rw, size: size});
        resp_q.push_back('{owner: owner, rdata: rdata, err: err});
    endtask

    task automatic wait_ack(input logic is_data, input int budget, output int cycles);
        bit seen;
        seen   = 0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(negedge clock);
            cycles++;
            if (is_data ? bus.d_ack : bus.f_ack) seen = 1;
        end
        if (!seen) begin
            check_output(is_data ? "d_ack_wait" : "f_ack_wait", 32'd0, 32'd1);
            cycles = -1;
        end
    endtask

    // Memory model: acks mem_lat cycles after seeing mem_req; negative latency never acks.
    initial begin
        int waited;
        bit abandoned;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clock);
            if (reset && bus.mem_req && !bus.mem_ack) begin
                waited    = 0;
                abandoned = 0;
                while (!abandoned && (mem_lat < 0 || waited < mem_lat)) begin
                    @(negedge clock);
                    waited++;
                    if (!reset || !bus.mem_req) abandoned = 1;
                end
                if (!abandoned) begin
                    bus.mem_rdata = mem_image.exists(bus.mem_addr) ? mem_image[bus.mem_addr] : 32'hA5A5A5A5;
                    bus.mem_ack   = 1'b1;
                    @(negedge clock);
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = 32'h0;
                end
            end
        end
    end

    // Monitor: grants are checked on mem_req rising, responses on each ack.
    initial begin
        logic        prev_req;
        logic [31:0] last_f, last_d;
        grant_t      g;
        resp_t       r;
        prev_req = 1'b0;
        last_f   = 32'h0;
        last_d   = 32'h0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_req = 1'b0;
                last_f   = 32'h0;
                last_d   = 32'h0;
            end else begin
                if (bus.mem_req && !prev_req) begin
                    if (grant_q.size() == 0) begin
                        check_output("unexpected_grant", bus.mem_addr, 32'hFFFFFFFF);
                    end else begin
                        g = grant_q.pop_front();
                        check_output("mem_addr", bus.mem_addr, g.addr);
                        check_output("mem_wdata", bus.mem_wdata, g.wdata);
                        check_output("mem_rw", {31'd0, bus.mem_rw}, {31'd0, g.rw});
                        check_output("mem_size", {30'd0, bus.mem_size}, {30'd0, g.size});
                    end
                end
                prev_req = bus.mem_req;
                if (bus.f_ack || bus.d_ack) begin
                    check_output("dual_ack", {31'd0, bus.f_ack & bus.d_ack}, 32'd0);
                    if (resp_q.size() == 0) begin
                        check_output("unexpected_ack", {30'd0, bus.d_ack, bus.f_ack}, 32'd0);
                    end else begin
                        r = resp_q.pop_front();
                        check_output("ack_owner", {31'd0, bus.d_ack}, {31'd0, r.owner});
                        check_output("err", {31'd0, bus.err}, {31'd0, r.err});
                        if (r.owner == OWN_D) begin
                            last_d = r.rdata;
                            check_output("d_rdata", bus.d_rdata, last_d);
                            check_output("f_rdata_hold", bus.f_rdata, last_f);
                        end else begin
                            last_f = r.rdata;
                            check_output("f_rdata", bus.f_rdata, last_f);
                            check_output("d_rdata_hold", bus.d_rdata, last_d);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation stalled");
    end

    initial begin
        int lat;
        int spins;

        reset       = 1'b0;
        bus.f_req   = 1'b0;
        bus.f_addr  = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        bus.d_rw    = RW_READ;
        bus.d_size  = SZ_WORD;

        mem_image[32'h01000000] = 32'h00000013;
        mem_image[32'h01000004] = 32'h00100093;
        mem_image[32'h01000008] = 32'h00200113;
        mem_image[32'h01000010] = 32'h00300193;
        mem_image[32'h01000200] = 32'h11112222;
        mem_image[32'h01000301] = 32'h000000AB;

        repeat (3) @(negedge clock);
        check_output("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check_output("rst_mem_addr", bus.mem_addr, 32'd0);
        check_output("rst_mem_size", {30'd0, bus.mem_size}, 32'd0);
        check_output("rst_f_ack", {31'd0, bus.f_ack}, 32'd0);
        check_output("rst_d_ack", {31'd0, bus.d_ack}, 32'd0);
        check_output("rst_f_rdata", bus.f_rdata, 32'd0);
        check_output("rst_d_rdata", bus.d_rdata, 32'd0);
        check_output("rst_err", {31'd0, bus.err}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        $display("[TB] single fetch");
        mem_lat = 2;
        apply_stimulus(OWN_F, 32'h01000000, 32'h0, RW_READ, SZ_WORD, 32'h00000013, 1'b0);
        bus.f_addr = 32'h01000000;
        bus.f_req  = 1'b1;
        #1 check_output("f_stall_wait", {31'd0, bus.f_stall}, 32'd1);
        wait_ack(1'b0, 20, lat);
        check_output("fetch_latency", lat, 32'd5);
        check_output("f_stall_ack", {31'd0, bus.f_stall}, 32'd0);
        bus.f_req = 1'b0;
        repeat (2) @(negedge clock);

        $display("[TB] simultaneous store and fetch");
        mem_lat = 0;
        apply_stimulus(OWN_D, 32'h01000100, 32'hDEADBEEF, RW_WRITE, SZ_WORD, 32'h0, 1'b0);
        apply_stimulus(OWN_F, 32'h01000004, 32'h0, RW_READ, SZ_WORD, 32'h00100093, 1'b0);
        bus.d_addr  = 32'h01000100;
        bus.d_wdata = 32'hDEADBEEF;
        bus.d_rw    = RW_WRITE;
        bus.d_size  = SZ_WORD;
        bus.d_req   = 1'b1;
        bus.f_addr  = 32'h01000004;
        bus.f_req   = 1'b1;
        #1 check_output("d_stall_wait", {31'd0, bus.d_stall}, 32'd1);
        wait_ack(1'b1, 20, lat);
        bus.d_req = 1'b0;
        wait_ack(1'b0, 20, lat);
        bus.f_req = 1'b0;
        repeat (2) @(negedge clock);

        $display("[TB] fetch starvation bound");
        for (int i = 0; i < MAX_STREAK; i++) begin
            apply_stimulus(OWN_D, 32'h01000200, 32'h0, RW_READ, SZ_WORD, 32'h11112222, 1'b0);
        end
        apply_stimulus(OWN_F, 32'h01000008, 32'h0, RW_READ, SZ_WORD, 32'h00200113, 1'b0);
        apply_stimulus(OWN_D, 32'h01000200, 32'h0, RW_READ, SZ_WORD, 32'h11112222, 1'b0);
        bus.d_addr  = 32'h01000200;
        bus.d_wdata = 32'h0;
        bus.d_rw    = RW_READ;
        bus.d_size  = SZ_WORD;
        bus.d_req   = 1'b1;
        bus.f_addr  = 32'h01000008;
        bus.f_req   = 1'b1;
        for (int i = 0; i < MAX_STREAK; i++) begin
            wait_ack(1'b1, 20, lat);
        end
        wait_ack(1'b0, 20, lat);
        bus.f_req = 1'b0;
        wait_ack(1'b1, 20, lat);
        bus.d_req = 1'b0;
        repeat (2) @(negedge clock);

        $display("[TB] byte load");
        apply_stimulus(OWN_D, 32'h01000301, 32'h0, RW_READ, SZ_BYTE, 32'h000000AB, 1'b0);
        bus.d_addr = 32'h01000301;
        bus.d_rw   = RW_READ;
        bus.d_size = SZ_BYTE;
        bus.d_req  = 1'b1;
        wait_ack(1'b1, 20, lat);
        check_output("min_latency", lat, 32'd3);
        bus.d_req = 1'b0;
        repeat (2) @(negedge clock);

`ifdef MEM_ARB_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        mem_lat = -1;
        apply_stimulus(OWN_D, 32'h01000500, 32'h0, RW_READ, SZ_WORD, 32'h0, 1'b1);
        bus.d_addr = 32'h01000500;
        bus.d_size = SZ_WORD;
        bus.d_req  = 1'b1;
        wait_ack(1'b1, 30, lat);
        check_output("timeout_latency", lat, 32'd10);
        bus.d_req = 1'b0;
        repeat (2) @(negedge clock);
`endif

        $display("[TB] reset during BUSY");
        mem_lat = 6;
        grant_q.push_back('{addr: 32'h01000400, wdata: 32'h0, rw: RW_READ, size: SZ_WORD});
        bus.d_addr = 32'h01000400;
        bus.d_size = SZ_WORD;
        bus.d_req  = 1'b1;
        spins = 0;
        while (!bus.mem_req && spins < 10) begin
            @(negedge clock);
            spins++;
        end
        check_output("busy_reached", {31'd0, bus.mem_req}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #1 check_output("rst_busy_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check_output("rst_busy_d_ack", {31'd0, bus.d_ack}, 32'd0);
        bus.d_req = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        mem_lat = 0;
        apply_stimulus(OWN_F, 32'h01000010, 32'h0, RW_READ, SZ_WORD, 32'h00300193, 1'b0);
        bus.f_addr = 32'h01000010;
        bus.f_req  = 1'b1;
        wait_ack(1'b0, 20, lat);
        check_output("post_reset_latency", lat, 32'd3);
        bus.f_req = 1'b0;
        repeat (4) @(negedge clock);

        check_output("grant_q_empty", grant_q.size(), 32'd0);
        check_output("resp_q_empty", resp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
